timer0_count_unit: RTL and testbench
====================================

// Module: timer0_count_unit
// PURPOSE
//   Next-state logic for the 8-bit Timer/Counter0 register file. Generates the
//   clock-select tick (prescaler or synchronised T0 pin), computes the next TCNT0
//   value (normal/CTC), raises one-cycle OCF/TOV set pulses and the two interrupt
//   requests. Drives TCNT_input and the flag-set inputs of the timer register block.
// PARAMETERS
//   PRESCALE_WIDTH  10  width of free-running prescaler counter (max divide 1024)
//   SYNC_STAGES     2   flip-flops in T0 pin synchroniser (>=2)
// PORTS
//   sysClock        in   1  system clock; all state on rising edge
//   system_reset    in   1  asynchronous, active-low reset
//   TCCR_value      in   8  TCCR0 contents; [2:0]=CS0, [6]=WGM00, [3]=WGM01
//   OCR_value       in   8  OCR0 contents
//   TCNT_value      in   8  current TCNT0 contents
//   TIMSK_value     in   8  [1]=OCIE0, [0]=TOIE0
//   TIFR_value      in   8  [1]=OCF0, [0]=TOV0
//   cpu_tcnt_write  in   1  CPU write strobe to TCNT0 this cycle
//   cpu_tcnt_data   in   8  CPU write data for TCNT0
//   prescaler_reset in   1  synchronous clear of prescaler (PSR10)
//   T0_pin          in   1  external clock pin, asynchronous
//   TCNT_next       out  8  value TCNT0 loads on next sysClock edge
//   tick            out  1  timer clock enable, one sysClock wide
//   ocf_set         out  1  one-cycle pulse: set OCF0
//   tov_set         out  1  one-cycle pulse: set TOV0
//   irq_compare     out  1  OCF0 & OCIE0
//   irq_overflow    out  1  TOV0 & TOIE0
// BEHAVIOUR
//   Reset (system_reset=0, async): prescaler=0, sync chain=0, edge reg=0,
//     block_cmp=0; tick=0, ocf_set=0, tov_set=0; TCNT_next=TCNT_value.
//   Prescaler: p increments every cycle while CS0!=000; prescaler_reset or
//     CS0==000 forces p=0 next cycle (wraps 2^PRESCALE_WIDTH-1 -> 0).
//   tick (registered, asserted cycle after condition):
//     000 never; 001 every cycle; 010 p[2:0]==7; 011 p[5:0]==63;
//     100 p[7:0]==255; 101 p[9:0]==1023;
//     110 falling edge of synchronised T0; 111 rising edge of synchronised T0.
//     Edge detect compares last sync stage with one extra delay reg;
//     pin-to-tick latency SYNC_STAGES+1 cycles. Prescaler_reset cancels pending
//     prescaled tick for the next cycle.
//   Mode: WGM01=1,WGM00=0 -> CTC; all other combinations -> normal.
//   TCNT_next priority (combinational):
//     1 cpu_tcnt_write -> cpu_tcnt_data; no ocf/tov pulse; sets block_cmp.
//     2 tick, CTC, TCNT_value==OCR_value -> 0x00.
//     3 tick -> TCNT_value+1 mod 256 (0xFF -> 0x00).
//     4 else -> TCNT_value.
//   ocf_set: tick & !cpu_tcnt_write & !block_cmp & TCNT_value==OCR_value.
//   tov_set: tick & !cpu_tcnt_write & TCNT_value==0xFF (normal, or CTC with
//     OCR_value==0xFF -> both pulses same cycle).
//   block_cmp: set by cpu_tcnt_write, cleared on first tick without write;
//     suppresses ocf_set for that one tick only.
//   irq_* combinational from TIFR/TIMSK; no latching here.
//   Flag clearing (write-1) is owned by the register block, not this unit.
//   CS0 change mid-count: takes effect next cycle; p not cleared unless 000.
// TESTING
//   CS0=001, normal, TCNT=0xFE -> next 0xFF, then 0x00 with tov_set=1 one cycle.
//   CS0=010, prescaler_reset pulsed -> tick exactly every 8 cycles, first 8 after.
//   CTC, OCR=0x05, CS0=001 from 0 -> counts 0..5, ocf_set at 5, wraps to 0, no tov.
//   CTC OCR=0xFF -> at 0xFF both ocf_set and tov_set, TCNT_next=0x00.
//   cpu_tcnt_write 0x10 with tick, OCR=0x10 -> TCNT_next=0x10, no ocf on next tick.
//   CS0=111, T0 toggled -> one tick per rising edge, latency 3; reset mid-count -> tick=0.

Source files
------------

// File: rtl/timer0_count_unit.sv
// Timer/Counter0 next-state unit: clock-select tick generation, TCNT0 next value
// (normal/CTC), one-cycle OCF0/TOV0 set pulses and the two interrupt requests.
module timer0_count_unit #(
  parameter int PRESCALE_WIDTH = 10,  // must be >= 10 for the clk/1024 tap
  parameter int SYNC_STAGES    = 2    // must be >= 2
) (
  input  logic       sysClock,
  input  logic       system_reset,
  input  logic [7:0] TCCR_value,
  input  logic [7:0] OCR_value,
  input  logic [7:0] TCNT_value,
  input  logic [7:0] TIMSK_value,
  input  logic [7:0] TIFR_value,
  input  logic       cpu_tcnt_write,
  input  logic [7:0] cpu_tcnt_data,
  input  logic       prescaler_reset,
  input  logic       T0_pin,
  output logic [7:0] TCNT_next,
  output logic       tick,
  output logic       ocf_set,
  output logic       tov_set,
  output logic       irq_compare,
  output logic       irq_overflow
);

  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_DIV1    = 3'b001,
    CS_DIV8    = 3'b010,
    CS_DIV64   = 3'b011,
    CS_DIV256  = 3'b100,
    CS_DIV1024 = 3'b101,
    CS_T0_FALL = 3'b110,
    CS_T0_RISE = 3'b111
  } clk_sel_e;

  clk_sel_e                  clk_sel;
  logic                      ctc_mode;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [SYNC_STAGES-1:0]    t0_sync;
  logic                      t0_last;
  logic                      t0_rise;
  logic                      t0_fall;
  logic                      tick_cond;
  logic                      block_cmp;
  logic                      cmp_match;
  logic                      unused_bits;

  assign clk_sel  = clk_sel_e'(TCCR_value[2:0]);
  assign ctc_mode = TCCR_value[3] & ~TCCR_value[6];

  // Edge detection looks at the last synchroniser stage against one extra delay.
  assign t0_rise = t0_sync[SYNC_STAGES-1] & ~t0_last;
  assign t0_fall = ~t0_sync[SYNC_STAGES-1] & t0_last;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    tick_cond = 1'b0;
    case (clk_sel)
      CS_STOP:    tick_cond = 1'b0;
      CS_DIV1:    tick_cond = 1'b1;
      CS_DIV8:    tick_cond = ~prescaler_reset & (&prescaler[2:0]);
      CS_DIV64:   tick_cond = ~prescaler_reset & (&prescaler[5:0]);
      CS_DIV256:  tick_cond = ~prescaler_reset & (&prescaler[7:0]);
      CS_DIV1024: tick_cond = ~prescaler_reset & (&prescaler[9:0]);
      CS_T0_FALL: tick_cond = t0_fall;
      CS_T0_RISE: tick_cond = t0_rise;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      prescaler <= '0;
      t0_sync   <= '0;
      t0_last   <= 1'b0;
      tick      <= 1'b0;
      block_cmp <= 1'b0;
    end else begin
      if (prescaler_reset || clk_sel == CS_STOP) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PRESCALE_WIDTH'(1);
      end
      t0_sync <= {t0_sync[SYNC_STAGES-2:0], T0_pin};
      t0_last <= t0_sync[SYNC_STAGES-1];
      tick    <= tick_cond;
      // A CPU write masks the compare match on the first timer tick that follows it.
      if (cpu_tcnt_write) begin
        block_cmp <= 1'b1;
      end else if (tick) begin
        block_cmp <= 1'b0;
      end
    end
  end

  assign cmp_match = (TCNT_value == OCR_value);

  always_comb begin
    TCNT_next = TCNT_value;
    if (!system_reset) begin
      TCNT_next = TCNT_value;
    end else if (cpu_tcnt_write) begin
      TCNT_next = cpu_tcnt_data;
    end else if (tick && ctc_mode && cmp_match) begin
      TCNT_next = 8'h00;
    end else if (tick) begin
      TCNT_next = TCNT_value + 8'd1;
    end
  end

  assign ocf_set = tick & ~cpu_tcnt_write & ~block_cmp & cmp_match;
  assign tov_set = tick & ~cpu_tcnt_write & (TCNT_value == 8'hFF);

  assign irq_compare  = TIFR_value[1] & TIMSK_value[1];
  assign irq_overflow = TIFR_value[0] & TIMSK_value[0];

  assign unused_bits = ^{TCCR_value[7], TCCR_value[5:4], TIMSK_value[7:2], TIFR_value[7:2]};

endmodule

// File: tb/tb_timer0_count_unit.sv
// Self-checking bench for timer0_count_unit: vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_timer0_count_unit;

  logic       clk = 1'b0;
  logic       system_reset;
  logic [7:0] tccr, ocr, tcnt, timsk, tifr;
  logic       wr;
  logic [7:0] wdata;
  logic       psr;
  logic       t0_pin;
  logic [7:0] tcnt_next;
  logic       tick, ocf_set, tov_set, irq_c, irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer0_count_unit dut (
    .sysClock       (clk),
    .system_reset   (system_reset),
    .TCCR_value     (tccr),
    .OCR_value      (ocr),
    .TCNT_value     (tcnt),
    .TIMSK_value    (timsk),
    .TIFR_value     (tifr),
    .cpu_tcnt_write (wr),
    .cpu_tcnt_data  (wdata),
    .prescaler_reset(psr),
    .T0_pin         (t0_pin),
    .TCNT_next      (tcnt_next),
    .tick           (tick),
    .ocf_set        (ocf_set),
    .tov_set        (tov_set),
    .irq_compare    (irq_c),
    .irq_overflow   (irq_o)
  );

  typedef struct {
    logic [7:0] tccr, ocr, tcnt, timsk, tifr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] exp_next;
    logic       exp_ocf, exp_tov, exp_irq_c, exp_irq_o;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state: cycles since prescaler clear, pin history, flags.
  int   pcnt;
  bit   tick_m, blk_m;
  bit   hist[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, exp);
    end
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  function automatic int div_of(input logic [2:0] cs);
    case (cs)
      3'd2:    return 8;
      3'd3:    return 64;
      3'd4:    return 256;
      3'd5:    return 1024;
      default: return 0;
    endcase
  endfunction

  task automatic model_init();
    pcnt   = 0;
    tick_m = 1'b0;
    blk_m  = 1'b0;
    hist.delete();
    repeat (4) hist.push_back(1'b0);
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_step();
    bit nt, rise, fall;
    int sz, dv;
    hist.push_back(t0_pin);
    if (hist.size() > 8) void'(hist.pop_front());
    sz   = hist.size();
    rise = hist[sz-3] & ~hist[sz-4];
    fall = ~hist[sz-3] & hist[sz-4];
    dv   = div_of(tccr[2:0]);
    case (tccr[2:0])
      3'd0:    nt = 1'b0;
      3'd1:    nt = 1'b1;
      3'd6:    nt = fall;
      3'd7:    nt = rise;
      default: nt = !psr && (pcnt % dv == dv - 1);
    endcase
    if (wr) blk_m = 1'b1;
    else if (tick_m) blk_m = 1'b0;
    pcnt   = (psr || tccr[2:0] == 3'd0) ? 0 : pcnt + 1;
    tick_m = nt;
  endtask

  task automatic model_check();
    logic [7:0] exp_next;
    bit         match, ctc;
    match = (tcnt == ocr);
    ctc   = tccr[3] && !tccr[6];
    if (wr) exp_next = wdata;
    else if (tick_m && ctc && match) exp_next = 8'h00;
    else if (tick_m) exp_next = 8'((int'(tcnt) + 1) % 256);
    else exp_next = tcnt;
    check("rnd_tick", 8'(tick), 8'(tick_m));
    check("rnd_next", tcnt_next, exp_next);
    check("rnd_ocf", 8'(ocf_set), 8'(tick_m && !wr && !blk_m && match));
    check("rnd_tov", 8'(tov_set), 8'(tick_m && !wr && tcnt == 8'hFF));
    check("rnd_irq_c", 8'(irq_c), 8'(tifr[1] && timsk[1]));
    check("rnd_irq_o", 8'(irq_o), 8'(tifr[0] && timsk[0]));
  endtask

  initial begin
    system_reset = 1'b0;
    tccr = 8'h01; ocr = 8'h5C; tcnt = 8'h5C; timsk = 8'h00; tifr = 8'h00;
    wr = 1'b1; wdata = 8'hAA; psr = 1'b0; t0_pin = 1'b0;

    // Reset: no tick or pulses, TCNT_next follows TCNT_value even with a write.
    repeat (2) to_next();
    to_sample();
    check("rst_tick", 8'(tick), 8'h00);
    check("rst_next", tcnt_next, 8'h5C);
    check("rst_ocf", 8'(ocf_set), 8'h00);
    check("rst_tov", 8'(tov_set), 8'h00);
    to_next();
    system_reset = 1'b1; wr = 1'b0; ocr = 8'h80; tcnt = 8'h00;
    repeat (2) to_next();

    // Vector table, CS0=001 so tick is high every cycle.
    //           tccr   ocr    tcnt   timsk  tifr   wr    wdata  next   ocf   tov   irqc  irqo
    vecs.push_back('{8'h01, 8'h80, 8'hFE, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h09, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h09, 8'h05, 8'h03, 8'h00, 8'h00, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h09, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h10, 8'h0F, 8'h00, 8'h00, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h49, 8'h20, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h41, 8'h30, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0, 8'h00, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h80, 8'h00, 8'h03, 8'h03, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{8'h01, 8'h80, 8'h00, 8'h01, 8'h03, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h01, 8'h80, 8'h00, 8'h02, 8'h02, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h01, 8'h80, 8'h00, 8'hFC, 8'hFF, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h09, 8'h05, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      tccr = vecs[i].tccr; ocr = vecs[i].ocr; tcnt = vecs[i].tcnt;
      timsk = vecs[i].timsk; tifr = vecs[i].tifr; wr = vecs[i].wr; wdata = vecs[i].wdata;
      to_sample();
      check($sformatf("vec%0d_next", i), tcnt_next, vecs[i].exp_next);
      check($sformatf("vec%0d_ocf", i), 8'(ocf_set), 8'(vecs[i].exp_ocf));
      check($sformatf("vec%0d_tov", i), 8'(tov_set), 8'(vecs[i].exp_tov));
      check($sformatf("vec%0d_irq_c", i), 8'(irq_c), 8'(vecs[i].exp_irq_c));
      check($sformatf("vec%0d_irq_o", i), 8'(irq_o), 8'(vecs[i].exp_irq_o));
      to_next();
    end
    wr = 1'b0; timsk = 8'h00; tifr = 8'h00;

    // clk/8 after a prescaler clear: first tick 8 cycles later, then every 8.
    tccr = 8'h02; ocr = 8'h80; tcnt = 8'h00;
    to_next();
    psr = 1'b1;
    to_next();
    psr = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      to_sample();
      check($sformatf("div8_tick_c%0d", k), 8'(tick), 8'(k != 0 && k % 8 == 0));
      to_next();
    end

    // CTC with OCR=5 counting up from 0: wraps after 5, no overflow.
    tccr = 8'h09; ocr = 8'h05;
    to_next();
    for (int k = 0; k < 14; k++) begin
      tcnt = 8'(k % 6);
      to_sample();
      check($sformatf("ctc_next_c%0d", k), tcnt_next, 8'((k % 6 == 5) ? 0 : k % 6 + 1));
      check($sformatf("ctc_ocf_c%0d", k), 8'(ocf_set), 8'(k % 6 == 5));
      check($sformatf("ctc_tov_c%0d", k), 8'(tov_set), 8'h00);
      to_next();
    end

    // External clock, rising then falling edge: latency of three cycles.
    tccr = 8'h07; t0_pin = 1'b0; tcnt = 8'h00;
    repeat (4) to_next();
    for (int k = 0; k < 32; k++) begin
      t0_pin = (k % 8) < 4;
      to_sample();
      check($sformatf("t0_rise_c%0d", k), 8'(tick), 8'(k >= 3 && (k - 3) % 8 == 0));
      to_next();
    end
    tccr = 8'h06; t0_pin = 1'b0;
    repeat (4) to_next();
    for (int k = 0; k < 32; k++) begin
      t0_pin = (k % 8) < 4;
      to_sample();
      check($sformatf("t0_fall_c%0d", k), 8'(tick), 8'(k >= 7 && (k - 7) % 8 == 0));
      to_next();
    end

    // Asynchronous reset in the middle of a counting cycle drops tick at once.
    tccr = 8'h01; t0_pin = 1'b0; ocr = 8'h22; tcnt = 8'h22;
    repeat (2) to_next();
    to_sample();
    check("pre_rst_tick", 8'(tick), 8'h01);
    check("pre_rst_ocf", 8'(ocf_set), 8'h01);
    #1 system_reset = 1'b0;
    #1;
    check("mid_rst_tick", 8'(tick), 8'h00);
    check("mid_rst_ocf", 8'(ocf_set), 8'h00);
    check("mid_rst_next", tcnt_next, 8'h22);

    // Randomized run against the model, starting from a fresh reset.
    psr = 1'b0; wr = 1'b0; t0_pin = 1'b0;
    to_next();
    system_reset = 1'b1;
    model_init();
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 299) == 0) tccr = 8'($urandom);
      if ($urandom_range(0, 29) == 0) ocr = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       tcnt = ocr;
        1:       tcnt = 8'hFF;
        default: tcnt = 8'($urandom);
      endcase
      wr    = ($urandom_range(0, 9) == 0);
      wdata = 8'($urandom);
      psr   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) t0_pin = ~t0_pin;
      timsk = 8'($urandom);
      tifr  = 8'($urandom);
      to_sample();
      model_check();
      model_step();
      to_next();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
